// File: rtl/systolic_feeder.sv
// systolic_feeder: captures four pre-skewed A row vectors and four B column
// vectors, then streams them one byte-lane beat at a time into the edges of
// a 4x4 systolic array under a valid/ready handshake.
// Optional feature macro: FEEDER_ZERO_FLUSH_EN. When it is defined, the feeder
// appends three all-zero beats after the seven data beats (10 beats in total).
module systolic_feeder #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7*DATA_W-1:0] a_r1,
  input  logic [7*DATA_W-1:0] a_r2,
  input  logic [7*DATA_W-1:0] a_r3,
  input  logic [7*DATA_W-1:0] a_r4,
  input  logic [7*DATA_W-1:0] b_c1,
  input  logic [7*DATA_W-1:0] b_c2,
  input  logic [7*DATA_W-1:0] b_c3,
  input  logic [7*DATA_W-1:0] b_c4,
  input  logic                start,
  input  logic                out_ready,
  output logic [4*DATA_W-1:0] a_out,
  output logic [4*DATA_W-1:0] b_out,
  output logic                feed_valid,
  output logic                busy,
  output logic                feed_done
);

  localparam int VEC_W = 7 * DATA_W;

`ifdef FEEDER_ZERO_FLUSH_EN
  // Seven data beats followed by three zero beats that drain the array.
  localparam logic [3:0] LAST_BEAT = 4'd9;
`else
  localparam logic [3:0] LAST_BEAT = 4'd6;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [VEC_W-1:0] a_sr_r [4];
  logic [VEC_W-1:0] b_sr_r [4];
  logic [VEC_W-1:0] a_in_s [4];
  logic [VEC_W-1:0] b_in_s [4];
  logic [3:0]       beat_cnt_r;
  logic             capture_s;
  logic             accept_s;
  logic             last_beat_s;

  assign a_in_s[0] = a_r1;
  assign a_in_s[1] = a_r2;
  assign a_in_s[2] = a_r3;
  assign a_in_s[3] = a_r4;
  assign b_in_s[0] = b_c1;
  assign b_in_s[1] = b_c2;
  assign b_in_s[2] = b_c3;
  assign b_in_s[3] = b_c4;

  // Start is honoured only while idle; a beat moves only when both sides agree.
  assign capture_s   = (state_r == IDLE) && start;
  assign accept_s    = (state_r == FEED) && out_ready;
  assign last_beat_s = (beat_cnt_r == LAST_BEAT);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection: IDLE -> FEED on start, FEED -> DONE after the final accepted beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = FEED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FEED: begin
        if (accept_s && last_beat_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = FEED;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Shift registers and beat counter: load on capture, shift left with zero fill on accept, else hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        a_sr_r[i] <= {VEC_W{1'b0}};
        b_sr_r[i] <= {VEC_W{1'b0}};
      end
      beat_cnt_r <= 4'd0;
    end else if (capture_s) begin
      for (int i = 0; i < 4; i++) begin
        a_sr_r[i] <= a_in_s[i];
        b_sr_r[i] <= b_in_s[i];
      end
      beat_cnt_r <= 4'd0;
    end else if (accept_s) begin
      for (int i = 0; i < 4; i++) begin
        a_sr_r[i] <= {a_sr_r[i][VEC_W-DATA_W-1:0], {DATA_W{1'b0}}};
        b_sr_r[i] <= {b_sr_r[i][VEC_W-DATA_W-1:0], {DATA_W{1'b0}}};
      end
      beat_cnt_r <= beat_cnt_r + 4'd1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        a_sr_r[i] <= a_sr_r[i];
        b_sr_r[i] <= b_sr_r[i];
      end
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Output decode: lanes present the top byte of each shift register only while feeding.
  always_comb begin
    feed_valid = 1'b0;
    busy       = 1'b0;
    feed_done  = 1'b0;
    a_out      = {(4*DATA_W){1'b0}};
    b_out      = {(4*DATA_W){1'b0}};
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      FEED: begin
        feed_valid = 1'b1;
        busy       = 1'b1;
        for (int i = 0; i < 4; i++) begin
          a_out[i*DATA_W +: DATA_W] = a_sr_r[i][VEC_W-1 -: DATA_W];
          b_out[i*DATA_W +: DATA_W] = b_sr_r[i][VEC_W-1 -: DATA_W];
        end
      end
      DONE: begin
        busy      = 1'b1;
        feed_done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: directed scenarios plus randomized
// transfers compared against a byte-lane reference model.
module tb_systolic_feeder;

`ifdef FEEDER_ZERO_FLUSH_EN
  localparam int BEATS = 10;
`else
  localparam int BEATS = 7;
`endif

  logic        clk;
  logic        reset;
  logic [55:0] a_r1, a_r2, a_r3, a_r4;
  logic [55:0] b_c1, b_c2, b_c3, b_c4;
  logic        start;
  logic        out_ready;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic        feed_valid;
  logic        busy;
  logic        feed_done;

  int errors = 0;
  int checks = 0;

  logic [31:0] beat_tbl [7] = '{32'h00000001, 32'h00000502, 32'h00000603,
                                32'h00000704, 32'h00000800, 32'h00000000,
                                32'h00000000};

  systolic_feeder #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .a_r1(a_r1), .a_r2(a_r2), .a_r3(a_r3), .a_r4(a_r4),
    .b_c1(b_c1), .b_c2(b_c2), .b_c3(b_c3), .b_c4(b_c4),
    .start(start), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out),
    .feed_valid(feed_valid), .busy(busy), .feed_done(feed_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: beat k of a vector is its k-th byte counted from the MSB, zero beyond 7.
  function automatic logic [31:0] lanes(input logic [3:0][55:0] v, input int k);
    logic [31:0] r;
    r = 32'h0;
    if (k < 7) begin
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = v[i][(6-k)*8 +: 8];
    end
    return r;
  endfunction

  task automatic drive(input logic [3:0][55:0] a, input logic [3:0][55:0] b);
    a_r1 = a[0]; a_r2 = a[1]; a_r3 = a[2]; a_r4 = a[3];
    b_c1 = b[0]; b_c2 = b[1]; b_c3 = b[2]; b_c4 = b[3];
  endtask

  function automatic logic [3:0][55:0] rand_vecs();
    logic [3:0][55:0] v;
    for (int i = 0; i < 4; i++) v[i] = 56'({$urandom(), $urandom()});
    return v;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(feed_valid), 32'h0);
    chk({tag, "_busy"},  32'(busy),       32'h0);
    chk({tag, "_done"},  32'(feed_done),  32'h0);
    chk({tag, "_a"},     a_out,           32'h0);
    chk({tag, "_b"},     b_out,           32'h0);
  endtask

  // Known two-row pattern, optionally stalling three cycles after beat 2.
  task automatic directed(input int stall);
    logic [3:0][55:0] a;
    logic [3:0][55:0] z;
    z = '0;
    a = '0;
    a[0] = 56'h01020304000000;
    a[1] = 56'h00050607080000;
    drive(a, z);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      chk("dir_valid", 32'(feed_valid), 32'h1);
      chk("dir_busy",  32'(busy),       32'h1);
      chk("dir_done",  32'(feed_done),  32'h0);
      chk("dir_a", a_out, (k < 7) ? beat_tbl[k] : 32'h0);
      chk("dir_b", b_out, 32'h0);
      if (k == 1) begin
        for (int s = 0; s < stall; s++) begin
          out_ready = 1'b0;
          step();
          chk("dir_hold_a", a_out, 32'h00000502);
          chk("dir_hold_valid", 32'(feed_valid), 32'h1);
        end
        out_ready = 1'b1;
      end
      step();
    end
    chk("dir_fdone", 32'(feed_done), 32'h1);
    chk("dir_fvalid", 32'(feed_valid), 32'h0);
    chk("dir_fa", a_out, 32'h0);
    step();
    chk_idle("dir_after");
  endtask

  // Random data, random stalls, stray starts and input changes after capture.
  task automatic rand_transfer(input int stall_pct);
    logic [3:0][55:0] av;
    logic [3:0][55:0] bv;
    int k;
    int guard;
    av = rand_vecs();
    bv = rand_vecs();
    drive(av, bv);
    start = 1'b1;
    step();
    start = 1'b0;
    drive(rand_vecs(), rand_vecs());
    k = 0;
    guard = 0;
    while (k < BEATS && guard < 400) begin
      chk("rnd_valid", 32'(feed_valid), 32'h1);
      chk("rnd_done",  32'(feed_done),  32'h0);
      chk("rnd_a", a_out, lanes(av, k));
      chk("rnd_b", b_out, lanes(bv, k));
      out_ready = ($urandom_range(99) >= stall_pct);
      start = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) drive(rand_vecs(), rand_vecs());
      step();
      if (out_ready) k++;
      guard++;
    end
    chk("rnd_beats", 32'(k), 32'(BEATS));
    chk("rnd_fdone", 32'(feed_done), 32'h1);
    chk("rnd_fvalid", 32'(feed_valid), 32'h0);
    chk("rnd_fa", a_out, 32'h0);
    chk("rnd_fb", b_out, 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_idle("rnd_lost_start");
  endtask

  initial begin
    logic [3:0][55:0] av;
    logic [3:0][55:0] bv;
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    drive('0, '0);
    step();
    step();
    chk_idle("reset");
    reset = 1'b1;

    // Start honoured on the first edge after release.
    directed(0);
    directed(3);

    // Reset in the middle of a transfer, then restart with fresh data.
    av = rand_vecs();
    bv = rand_vecs();
    drive(av, bv);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mid_a", a_out, lanes(av, k));
      step();
    end
    chk("mid_beat4_a", a_out, lanes(av, 3));
    reset = 1'b0;
    #1;
    chk_idle("mid_reset");
    step();
    reset = 1'b1;
    chk_idle("post_reset");
    rand_transfer(0);

    for (int t = 0; t < 20; t++) rand_transfer($urandom_range(70));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter: DATA_W, default 8, byte width per lane; each row/column vector SHALL be 7*DATA_W bits wide.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Ports: a_r1..a_r4  input  7*DATA_W each  pre-skewed A row vectors, already zero-padded per lane.
REQ-005 Ports: b_c1..b_c4  input  7*DATA_W each  pre-skewed B column vectors, already zero-padded per lane.
REQ-006 Port: start  input  1  single-cycle request to capture all eight vectors (driven from load_done).
REQ-007 Port: out_ready  input  1  systolic array accepts the current beat.
REQ-008 Port: a_out  output  4*DATA_W  A-edge lanes; lane i occupies bits [DATA_W*i +: DATA_W], lane 0 is a_r1.
REQ-009 Port: b_out  output  4*DATA_W  B-edge lanes; same packing, lane 0 is b_c1.
REQ-010 Port: feed_valid  output  1  a_out/b_out hold a valid beat.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: feed_done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-013 FSM states SHALL be IDLE, FEED and DONE.
REQ-014 IDLE: on start=1, all eight inputs SHALL be captured into internal shift registers, the beat counter SHALL be cleared, and the next state SHALL be FEED.
REQ-015 FEED: feed_valid SHALL be 1; each lane output SHALL be the most-significant DATA_W bits of its shift register.
REQ-016 A beat SHALL be accepted when feed_valid=1 and out_ready=1; on acceptance, every shift register SHALL shift left by DATA_W with zero fill and the beat counter SHALL increment.
REQ-017 With out_ready=0, shift registers, counter and outputs SHALL hold unchanged (stall of any length).
REQ-018 On acceptance of the final beat (counter = BEATS-1), the next state SHALL be DONE; BEATS=7.
REQ-019 DONE: feed_done=1 and feed_valid=0 for exactly one cycle, then the next state SHALL be IDLE.
REQ-020 First beat SHALL be visible the cycle after start is sampled; the minimum transfer is 7 FEED cycles plus 1 DONE cycle.
REQ-021 start SHALL be ignored in FEED and DONE; a start arriving in the DONE cycle is lost, and start is accepted again only in IDLE.
REQ-022 Input vectors SHALL be sampled only at capture; later changes SHALL NOT affect the beats in flight.
REQ-023 In IDLE and DONE, a_out and b_out SHALL be 0.

Reset
REQ-024 Asserting reset (low) SHALL, at any time including mid-FEED, force IDLE and clear all shift registers and the counter.
REQ-025 While reset is low: a_out=0, b_out=0, feed_valid=0, busy=0, feed_done=0.
REQ-026 After reset deasserts, the first start SHALL be honoured on the first rising clock edge.

Configuration
REQ-027 Macro FEEDER_ZERO_FLUSH_EN defined: after the 7 data beats, the block SHALL emit 3 additional all-zero beats with feed_valid=1, under the same stall rules, before DONE (BEATS=10).
REQ-028 Macro FEEDER_ZERO_FLUSH_EN undefined: BEATS=7, and no flush logic SHALL be present.

Verification
REQ-029 Setup: a_r1={32'h01020304,24'h0}, a_r2={8'h0,32'h05060708,16'h0}, all others 0; pulse start with out_ready=1. Required: a_out = 0x00000001, 0x00000502, 0x00000603, 0x00000704, 0x00000800, 0, 0; then feed_done pulses once.
REQ-030 Same setup, with out_ready=0 for 3 cycles after beat 2. Required: a_out stays at 0x00000502 for 4 cycles, the remaining sequence is unchanged, and feed_done is 3 cycles later than in REQ-029.
REQ-031 Pulse start again during FEED, with new input values. Required: no effect on the current sequence or the counter.
REQ-032 Assert reset at beat 4. Required: all outputs 0 immediately; a start after release restarts from beat 1 with newly captured data.
REQ-033 Change b_c1 one cycle after capture. Required: b_out sequence reflects the captured value only.
REQ-034 With FEEDER_ZERO_FLUSH_EN defined, repeat REQ-029. Required: 10 valid beats, the last 3 all zero, then feed_done.
